// File: rtl/memory_pkg.sv
// Shared types and helpers for the multi-read-port scratch memory.
package memory_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  localparam int MERGE_W = 64;

  // Bits whose lane is enabled come from new_word, all others from old_word.
  function automatic logic [MERGE_W-1:0] lane_merge(
    input logic [MERGE_W-1:0] old_word,
    input logic [MERGE_W-1:0] new_word,
    input logic [MERGE_W-1:0] lane_en,
    input int                 lane_w
  );
    logic [MERGE_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MERGE_W; b++) begin
      if (lane_en[6'(b / lane_w)]) merged[6'(b)] = new_word[6'(b)];
    end
    return merged;
  endfunction

endpackage

// File: rtl/memory_clr_fsm.sv
// Clear sequencer: sweeps every word after reset or an accepted clear request.
module memory_clr_fsm
  import memory_pkg::*;
#(
  parameter int MEM_SIZE  = 6,
  parameter int ADDR_SIZE = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_req,
  output logic                 busy,
  output logic                 clr_we,
  output logic [ADDR_SIZE-1:0] clr_addr
);

  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_SIZE - 1);

  state_t               state, next_state;
  logic [ADDR_SIZE-1:0] clr_cnt, next_cnt;
  logic                 sweep;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= next_state;
      clr_cnt <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = clr_cnt;
    sweep      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (clear_req) begin
          next_state = ST_CLEAR;
          next_cnt   = '0;
        end
      end
      ST_CLEAR: begin
        sweep = 1'b1;
        if (clr_cnt == LAST) next_state = ST_IDLE;
        else                 next_cnt   = clr_cnt + ADDR_SIZE'(1);
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Reset holds the array untouched but already reports the memory as busy.
  assign busy     = rst | (state == ST_CLEAR);
  assign clr_we   = sweep & ~rst;
  assign clr_addr = clr_cnt;

endmodule

// File: rtl/memory_mp.sv
// Multi-read-port memory with lane-masked writes, hardware clear and out-of-range flag.
module memory_mp
  import memory_pkg::*;
#(
  parameter int                MEM_SIZE  = 6,
  parameter int                DATA_W    = 10,
  parameter int                ADDR_SIZE = $clog2(MEM_SIZE),
  parameter int                RD_PORTS  = 2,
  parameter int                LANE_W    = 5,
  parameter int                LANES     = DATA_W / LANE_W,
  parameter int                RD_MODE   = 0,
  parameter int                OUT_REG   = 0,
  parameter logic [DATA_W-1:0] CLR_VAL   = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write_flag,
  input  logic [ADDR_SIZE-1:0]          addr_w,
  input  logic [DATA_W-1:0]             data_in,
  input  logic [LANES-1:0]              lane_en,
  input  logic [RD_PORTS-1:0]           read_flag,
  input  logic [RD_PORTS*ADDR_SIZE-1:0] addr_r,
  output logic [RD_PORTS*DATA_W-1:0]    data_out,
  output logic [RD_PORTS-1:0]           data_valid,
  input  logic                          clear_req,
  output logic                          busy,
  output logic                          err_addr
);

  localparam logic [ADDR_SIZE:0] MEM_LIM = (ADDR_SIZE + 1)'(MEM_SIZE);

  logic [DATA_W-1:0]    mem [MEM_SIZE];
  logic                 clr_we;
  logic [ADDR_SIZE-1:0] clr_addr;
  logic                 idle, wr_req, wr_in_range, clear_accept;
  logic [ADDR_SIZE-1:0] wr_idx;
  logic [DATA_W-1:0]    wr_merged;
  logic [RD_PORTS-1:0]  rd_oor;

  memory_clr_fsm #(
    .MEM_SIZE (MEM_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clear_req(clear_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign idle         = ~busy;
  assign wr_req       = idle & write_flag;
  assign clear_accept = idle & clear_req;
  assign wr_in_range  = {1'b0, addr_w} < MEM_LIM;
  assign wr_idx       = wr_in_range ? addr_w : '0;
  assign wr_merged    = DATA_W'(lane_merge(64'(mem[wr_idx]), 64'(data_in),
                                           64'(lane_en), LANE_W));

  // The sweep owns the write port while it runs; user writes are only taken when idle.
  always_ff @(posedge clk) begin
    if (clr_we)                    mem[clr_addr] <= CLR_VAL;
    else if (wr_req && wr_in_range) mem[wr_idx]  <= wr_merged;
  end

  always_ff @(posedge clk) begin
    if (rst)                                        err_addr <= 1'b0;
    else if ((wr_req && !wr_in_range) || |rd_oor)   err_addr <= 1'b1;
    else if (clear_accept)                          err_addr <= 1'b0;
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_SIZE-1:0] ra, ra_idx;
    logic                 rd_req, rd_in_range, hit, s1_valid;
    logic [DATA_W-1:0]    rd_word, s1_data;

    assign ra          = addr_r[p*ADDR_SIZE +: ADDR_SIZE];
    assign rd_req      = idle & read_flag[p];
    assign rd_in_range = {1'b0, ra} < MEM_LIM;
    assign ra_idx      = rd_in_range ? ra : '0;
    assign rd_oor[p]   = rd_req & ~rd_in_range;
    assign hit         = (RD_MODE == WR_FIRST) && wr_req && wr_in_range && (addr_w == ra);

    // Write-first forwards the merged word; read-first sees the array before the write lands.
    always_comb begin
      rd_word = '0;
      if (rd_in_range) rd_word = hit ? wr_merged : mem[ra_idx];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
      end else begin
        s1_valid <= rd_req;
        if (rd_req) s1_data <= rd_word;
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic              s2_valid;
      logic [DATA_W-1:0] s2_data;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign data_out[p*DATA_W +: DATA_W] = s2_data;
      assign data_valid[p]                = s2_valid;
    end else begin : g_direct
      assign data_out[p*DATA_W +: DATA_W] = s1_data;
      assign data_valid[p]                = s1_valid;
    end
  end

endmodule

// File: tb/tb_memory_mp.sv
// Self-checking bench: read-first/no-output-reg and write-first/output-reg instances share stimulus.
module tb_memory_mp;

  localparam int MEM_SIZE = 6;

  logic        clk = 1'b0;
  logic        rst, write_flag, clear_req;
  logic [2:0]  addr_w;
  logic [9:0]  data_in;
  logic [1:0]  lane_en, read_flag;
  logic [5:0]  addr_r;
  logic [19:0] dout0, dout1;
  logic [1:0]  dv0, dv1;
  logic        busy0, busy1, err0, err1;

  int compared   = 0;
  int mismatched = 0;
  bit checking   = 1'b0;
  int cycles;

  always #5 clk = ~clk;

  memory_mp dut0 (
    .clk(clk), .rst(rst), .write_flag(write_flag), .addr_w(addr_w), .data_in(data_in),
    .lane_en(lane_en), .read_flag(read_flag), .addr_r(addr_r), .data_out(dout0),
    .data_valid(dv0), .clear_req(clear_req), .busy(busy0), .err_addr(err0)
  );

  memory_mp #(.RD_MODE(1), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .write_flag(write_flag), .addr_w(addr_w), .data_in(data_in),
    .lane_en(lane_en), .read_flag(read_flag), .addr_r(addr_r), .data_out(dout1),
    .data_valid(dv1), .clear_req(clear_req), .busy(busy1), .err_addr(err1)
  );

  // Reference model: array contents, remaining sweep words, error flag, expected outputs.
  logic [9:0] mm [MEM_SIZE];
  int         sweep_left = 0;
  bit         merr = 1'b0;
  logic [9:0] e0d [2], e1d [2], s1d [2];
  bit         e0v [2], e1v [2], s1v [2];

  function automatic logic [9:0] merge(input logic [9:0] old, input logic [9:0] nw,
                                       input logic [1:0] le);
    logic [9:0] m;
    m = (le[0] ? 10'h01F : 10'h000) | (le[1] ? 10'h3E0 : 10'h000);
    return (nw & m) | (old & ~m);
  endfunction

  always @(posedge clk) begin
    bit         rq [2];
    logic [9:0] rv0 [2], rv1 [2];
    bit         oor;
    int         a;
    if (rst) begin
      checking   = 1'b1;
      sweep_left = MEM_SIZE;
      merr       = 1'b0;
      for (int p = 0; p < 2; p++) begin
        e0d[p] = '0; e1d[p] = '0; s1d[p] = '0;
        e0v[p] = 0;  e1v[p] = 0;  s1v[p] = 0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        rq[p] = 0; rv0[p] = '0; rv1[p] = '0;
      end
      if (sweep_left > 0) begin
        mm[MEM_SIZE - sweep_left] = 10'h000;
        sweep_left--;
      end else begin
        oor = 0;
        for (int p = 0; p < 2; p++) begin
          rq[p] = read_flag[p];
          a     = int'(addr_r[p*3 +: 3]);
          if (rq[p]) begin
            if (a >= MEM_SIZE) oor = 1;
            else begin
              rv0[p] = mm[a];
              rv1[p] = (write_flag && int'(addr_w) == a) ? merge(mm[a], data_in, lane_en) : mm[a];
            end
          end
        end
        if (write_flag) begin
          if (int'(addr_w) >= MEM_SIZE) oor = 1;
          else mm[addr_w] = merge(mm[addr_w], data_in, lane_en);
        end
        if (oor) merr = 1'b1;
        else if (clear_req) merr = 1'b0;
        if (clear_req) sweep_left = MEM_SIZE;
      end
      for (int p = 0; p < 2; p++) begin
        e0v[p] = rq[p];
        if (rq[p]) e0d[p] = rv0[p];
        e1v[p] = s1v[p];
        if (s1v[p]) e1d[p] = s1d[p];
        s1v[p] = rq[p];
        if (rq[p]) s1d[p] = rv1[p];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (checking) begin
      checkOutput("model busy0", 32'(busy0), 32'(rst || sweep_left > 0));
      checkOutput("model busy1", 32'(busy1), 32'(rst || sweep_left > 0));
      checkOutput("model err0", 32'(err0), 32'(merr));
      checkOutput("model err1", 32'(err1), 32'(merr));
      checkOutput("model valid0", 32'(dv0), 32'({e0v[1], e0v[0]}));
      checkOutput("model valid1", 32'(dv1), 32'({e1v[1], e1v[0]}));
      checkOutput("model data0", 32'(dout0), 32'({e0d[1], e0d[0]}));
      checkOutput("model data1", 32'(dout1), 32'({e1d[1], e1d[0]}));
    end
  end

  task automatic applyStimulus(input logic r, input logic wf, input logic [2:0] aw,
                               input logic [9:0] din, input logic [1:0] le,
                               input logic [1:0] rf, input logic [2:0] a0,
                               input logic [2:0] a1, input logic cr);
    @(negedge clk);
    rst = r; write_flag = wf; addr_w = aw; data_in = din; lane_en = le;
    read_flag = rf; addr_r = {a1, a0}; clear_req = cr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy drops, while optionally hammering the ports with ignored requests.
  task automatic countBusy(input logic first_rst, input bit hammer, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      if (hammer) applyStimulus(i == 1 ? first_rst : 1'b0, 1'b1, 3'd3, 10'h3FF, 2'b11,
                                2'b11, 3'd3, 3'd3, 1'b0);
      else        applyStimulus(i == 1 ? first_rst : 1'b0, 1'b0, 3'd0, 10'h000, 2'b00,
                                2'b00, 3'd0, 3'd0, 1'b0);
      step();
      if (hammer) checkOutput("busy read valid", 32'(dv0), 32'd0);
      if (!busy0) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; write_flag = 0; addr_w = '0; data_in = '0; lane_en = '0;
    read_flag = '0; addr_r = '0; clear_req = 0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy0), 32'd1);
    checkOutput("reset valid", 32'(dv0), 32'd0);
    checkOutput("reset data", 32'(dout1), 32'd0);
    checkOutput("reset err", 32'(err0), 32'd0);
    countBusy(1'b0, 0, cycles);
    checkOutput("sweep after reset cycles", 32'(cycles), 32'd6);

    for (int a = 0; a < 6; a++) begin
      applyStimulus(0, 0, 0, 0, 0, 2'b01, 3'(a), 0, 0);
      step();
      checkOutput($sformatf("swept word %0d", a), 32'(dout0[9:0]), 32'd0);
      checkOutput($sformatf("swept valid %0d", a), 32'(dv0[0]), 32'd1);
    end

    applyStimulus(0, 1, 3'd2, 10'h3FF, 2'b11, 0, 0, 0, 0);
    applyStimulus(0, 1, 3'd2, 10'h000, 2'b01, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 2'b01, 3'd2, 0, 0);
    step();
    checkOutput("lane write rd0", 32'(dout0[9:0]), 32'h3E0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("lane write rd1", 32'(dout1[9:0]), 32'h3E0);

    applyStimulus(0, 1, 3'd4, 10'h155, 2'b11, 0, 0, 0, 0);
    applyStimulus(0, 1, 3'd4, 10'h2AA, 2'b11, 2'b10, 0, 3'd4, 0);
    step();
    checkOutput("read-first old word", 32'(dout0[19:10]), 32'h155);
    checkOutput("read-first valid", 32'(dv0[1]), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("write-first new word", 32'(dout1[19:10]), 32'h2AA);
    checkOutput("write-first valid", 32'(dv1[1]), 32'd1);

    applyStimulus(0, 1, 3'd1, 10'h0AB, 2'b11, 0, 0, 0, 0);
    applyStimulus(0, 1, 3'd5, 10'h3C3, 2'b11, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 2'b11, 3'd1, 3'd5, 0);
    step();
    checkOutput("outreg valid early", 32'(dv1), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("outreg valid", 32'(dv1), 32'd3);
    checkOutput("outreg data", 32'(dout1), 32'({10'h3C3, 10'h0AB}));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("outreg valid pulse", 32'(dv1), 32'd0);

    applyStimulus(0, 1, 3'd7, 10'h3FF, 2'b11, 2'b01, 3'd6, 0, 0);
    step();
    checkOutput("oor read data", 32'(dout0[9:0]), 32'd0);
    checkOutput("oor read valid", 32'(dv0[0]), 32'd1);
    checkOutput("oor err set", 32'(err0), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("oor err sticky", 32'(err1), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    checkOutput("clear err", 32'(err0), 32'd0);
    checkOutput("clear busy", 32'(busy0), 32'd1);
    countBusy(1'b0, 0, cycles);
    checkOutput("clear sweep cycles", 32'(cycles + 1), 32'd7);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    countBusy(1'b0, 1, cycles);
    checkOutput("restart sweep cycles", 32'(cycles), 32'd6);
    applyStimulus(0, 0, 0, 0, 0, 2'b11, 3'd3, 3'd1, 0);
    step();
    checkOutput("busy write lost", 32'(dout0[9:0]), 32'd0);
    checkOutput("swept after restart", 32'(dout0[19:10]), 32'd0);

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 149) == 0, 1'($urandom), 3'($urandom_range(0, 7)),
                    10'($urandom), 2'($urandom), 2'($urandom), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), $urandom_range(0, 39) == 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/memory_mp.md
# memory_mp

Parametrised multi-read-port successor to the single-port-pair block memory. It provides one write port with per-lane write enables and `RD_PORTS` independent synchronous read ports. Read-during-write behaviour and an optional output pipeline stage are selectable. A hardware clear sequencer sweeps the array after reset or on request, and a sticky flag records out-of-range accesses. It is the team's general on-chip scratch/coefficient store.

## Interface
- `MEM_SIZE`, 6, number of words (need not be a power of two)
- `DATA_W`, 10, word width
- `ADDR_SIZE`, $clog2(MEM_SIZE), address width
- `RD_PORTS`, 2, number of read ports (≥1)
- `LANE_W`, 5, write-lane width; DATA_W must be a multiple of LANE_W
- `LANES`, DATA_W/LANE_W, derived lane count
- `RD_MODE`, 0, read-during-write: 0 = read-first (old data), 1 = write-first (new data)
- `OUT_REG`, 0, 1 adds an output register stage
- `CLR_VAL`, 0, DATA_W-bit value written by the clear sweep

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `write_flag`  in  1  write request
- `addr_w`  in  ADDR_SIZE  write address
- `data_in`  in  DATA_W  write data
- `lane_en`  in  LANES  per-lane write enable; lane i = bits [i*LANE_W +: LANE_W]
- `read_flag`  in  RD_PORTS  per-port read request
- `addr_r`  in  RD_PORTS*ADDR_SIZE  packed read addresses, port p at [p*ADDR_SIZE +: ADDR_SIZE]
- `data_out`  out  RD_PORTS*DATA_W  packed read data, port p at [p*DATA_W +: DATA_W]
- `data_valid`  out  RD_PORTS  per-port read-data valid
- `clear_req`  in  1  start a clear sweep (honoured in IDLE only)
- `busy`  out  1  clear sweep in progress; requests ignored
- `err_addr`  out  1  sticky out-of-range access flag

## Operation
- FSM states are IDLE and CLEAR, with sweep counter `clr_cnt` (ADDR_SIZE bits).
- `rst` forces CLEAR with clr_cnt=0. No array write occurs while rst is high.
- In CLEAR, each cycle writes CLR_VAL to word clr_cnt, then increments. At clr_cnt==MEM_SIZE-1 the word is written and the FSM goes to IDLE.
- In IDLE, `clear_req`=1 moves to CLEAR with clr_cnt=0 on the next cycle. Same-cycle reads and writes still execute.
- `clear_req` while busy is ignored.
- In CLEAR, `write_flag`, `read_flag` and `clear_req` are ignored. `data_valid` is 0 for reads requested in CLEAR.
- Write in IDLE: lanes with lane_en=1 are updated and other lanes are kept. `lane_en`=0 is a legal no-op.
- Read in IDLE: each port reads independently. Any ports may share an address.
- Write and read to the same address in the same cycle:
  - RD_MODE=0 returns the pre-write word.
  - RD_MODE=1 returns enabled lanes from `data_in` and the rest from the old word.
- Out-of-range address (≥MEM_SIZE):
  - A write is dropped.
  - A read returns 0 with data_valid=1.
  - Either sets `err_addr`.
- `err_addr` clears on rst, or on clear_req accepted in IDLE. Set takes priority when both occur in the same cycle.
- `data_out[p]` holds its last value when no read is issued on port p.

## Timing
- Reset values:
  - `data_out`=0 and `data_valid`=0.
  - `err_addr`=0.
  - `busy`=1 while rst is high.
- After rst falls, `busy` stays 1 for exactly MEM_SIZE cycles, then drops to 0 in IDLE.
- `busy` is 1 for exactly MEM_SIZE cycles after an accepted clear_req, starting the cycle after the request.
- Read latency is 1+OUT_REG cycles from the sampled read_flag to data_out/data_valid.
- `data_valid` is a single-cycle pulse per read, aligned with data_out.
- A write is visible to a read issued the next cycle, regardless of RD_MODE.
- rst mid-sweep restarts the sweep at word 0. rst also flushes the OUT_REG stage, so no valid is emitted.
- `err_addr` is set one cycle after the offending request is sampled.

## Structure
- Package `memory_pkg` holds:
  - state enum (`ST_IDLE`, `ST_CLEAR`)
  - RD_MODE constants (`RD_FIRST`=0, `WR_FIRST`=1)
  - lane-merge function (old, new, lane_en) → merged word
- Sub-module `memory_clr_fsm` contains the FSM, clr_cnt and busy. Its outputs are clear-write enable and clear address.
- The top level holds the array, the write/clear mux, per-port read paths (generate loop) and the optional output stage.

## Test plan
- Reset then sweep, default params: rst for 3 cycles, release. Required: busy=1 for 6 cycles. Reads of addresses 0–5 then return 0 with valid after 1 cycle.
- Lane write: write 10'h3FF with all lanes enabled, then 10'h000 with lane_en=2'b01 to address 2. Required: a port-0 read returns 10'h3E0.
- Read-during-write: address 4 holds 10'h155; write 10'h2AA with all lanes enabled while port 1 reads address 4. Required: RD_MODE=0 returns 10'h155, RD_MODE=1 returns 10'h2AA.
- Multi-port, OUT_REG=1: port 0 reads address 1 and port 1 reads address 5 in the same cycle. Required: both data_valid high exactly 2 cycles later with the correct words.
- Out-of-range: write address 7, read address 6. Required: array unchanged, read data 0 with valid=1, err_addr=1 on the next cycle and remaining set until clear_req.
- Clear mid-operation: issue clear_req, and assert rst after 3 sweep cycles. Required: the sweep restarts and busy stays high for 6 cycles after rst falls. Writes issued while busy are lost, and read_flag while busy gives data_valid=0.
